// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the RV64 datapath (FETCH/DECODE/EXECUTE/MEM/WB/TRAP).
// Optional performance counters are built when MC_PERF_COUNTERS_EN is defined.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        Zero,
  input  logic        BLT,
  input  logic        dmem_ready,
  input  logic        stall,
  output logic        pc_write,
  output logic        ir_write,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        pc_src,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic [1:0]  ALUOp,
  output logic        trap,
  output logic [2:0]  state,
  output logic [63:0] cycle_count,
  output logic [63:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t state_reg;
  state_t state_next;

  logic is_r, is_i, is_load, is_store, is_branch;
  logic taken;

  always_comb begin
    is_r      = (opcode == OP_R);
    is_i      = (opcode == OP_I);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_branch = (opcode == OP_BRANCH);
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = BLT;
      3'b101:  taken = !BLT;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    pc_src     = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    ALUOp      = 2'b00;
    trap       = 1'b0;

    case (state_reg)
      S_FETCH: begin
        ir_write   = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_r || is_i || is_load || is_store || is_branch) begin
          state_next = S_EXECUTE;
        end else begin
          state_next = S_TRAP;
        end
      end
      S_EXECUTE: begin
        if (is_r) begin
          ALUOp      = 2'b10;
          state_next = S_WB;
        end else if (is_i) begin
          ALUOp      = 2'b10;
          ALUSrc     = 1'b1;
          state_next = S_WB;
        end else if (is_load || is_store) begin
          ALUSrc     = 1'b1;
          state_next = S_MEM;
        end else if (is_branch) begin
          ALUOp      = 2'b01;
          pc_write   = 1'b1;
          pc_src     = taken;
          state_next = S_FETCH;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_MEM: begin
        if (is_load) begin
          MemRead = 1'b1;
          if (dmem_ready) begin
            state_next = S_WB;
          end
        end else if (is_store) begin
          MemWrite = 1'b1;
          if (dmem_ready) begin
            pc_write   = 1'b1;
            state_next = S_FETCH;
          end
        end else begin
          state_next = S_FETCH;
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = is_load;
        pc_write   = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        trap       = 1'b1;
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase

    // A stall freezes the sequence and swallows every enable, including a pending dmem_ready.
    if (stall) begin
      state_next = state_reg;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
    end

    if (reset) begin
      pc_write = 1'b0;
      ir_write = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      pc_src   = 1'b0;
      ALUSrc   = 1'b0;
      MemtoReg = 1'b0;
      ALUOp    = 2'b00;
      trap     = 1'b0;
    end
  end

  assign state = reset ? 3'd0 : state_reg;

`ifdef MC_PERF_COUNTERS_EN
  logic [63:0] cycle_count_reg;
  logic [63:0] instret_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_reg <= 64'd0;
      instret_reg     <= 64'd0;
    end else begin
      cycle_count_reg <= cycle_count_reg + 64'd1;
      if (pc_write) begin
        instret_reg <= instret_reg + 64'd1;
      end
    end
  end

  assign cycle_count = reset ? 64'd0 : cycle_count_reg;
  assign instret     = reset ? 64'd0 : instret_reg;
`else
  assign cycle_count = 64'd0;
  assign instret     = 64'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven check of multicycle_controller: one input vector per clock cycle,
// outputs compared mid-cycle, plus hand sequences for trap, reset-in-MEM and counters.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset, Zero, BLT, dmem_ready, stall;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        pc_write, ir_write, RegWrite, MemRead, MemWrite;
  logic        pc_src, ALUSrc, MemtoReg, trap;
  logic [1:0]  ALUOp;
  logic [2:0]  state;
  logic [63:0] cycle_count, instret;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .Zero(Zero), .BLT(BLT),
    .dmem_ready(dmem_ready), .stall(stall), .pc_write(pc_write), .ir_write(ir_write),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .pc_src(pc_src),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .ALUOp(ALUOp), .trap(trap), .state(state),
    .cycle_count(cycle_count), .instret(instret)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdy;
    logic        zero;
    logic        blt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[$];

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, BAD = 7'b1111111;

  // Packed as {pc_write, ir_write, RegWrite, MemRead, MemWrite, pc_src, ALUSrc, MemtoReg, ALUOp, trap, state}
  function automatic logic [14:0] mk(input logic pcw, irw, rw, mr, mw, psrc, asrc, m2r,
                                     input logic [1:0] aop, input logic tr, input logic [2:0] st);
    return {pcw, irw, rw, mr, mw, psrc, asrc, m2r, aop, tr, st};
  endfunction

  function automatic logic [14:0] outs();
    return {pc_write, ir_write, RegWrite, MemRead, MemWrite, pc_src, ALUSrc, MemtoReg,
            ALUOp, trap, state};
  endfunction

  task automatic add(input logic rst, stl, rdy, zero, blt, input logic [6:0] op,
                     input logic [2:0] f3, input logic [14:0] exp);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdy = rdy; v.zero = zero; v.blt = blt;
    v.op = op; v.f3 = f3; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    reset = v.rst; stall = v.stl; dmem_ready = v.rdy; Zero = v.zero; BLT = v.blt;
    opcode = v.op; funct3 = v.f3;
    #1;
    $display("%s rst=%0b stall=%0b rdy=%0b op=%b f3=%b out=%h exp=%h",
             nm, v.rst, v.stl, v.rdy, v.op, v.f3, outs(), v.exp);
    check(nm, {49'd0, outs()}, {49'd0, v.exp});
  endtask

  task automatic cyc(input logic rst, stl, rdy, input logic [6:0] op,
                     input logic [14:0] exp, input string nm);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdy = rdy; v.zero = 1'b0; v.blt = 1'b0;
    v.op = op; v.f3 = 3'b000; v.exp = exp;
    step(v, nm);
  endtask

  logic [14:0] X0, XF, XD, XER, XEI, XEM, XEBT, XEBN, XEBS, XWB, XWBL;
  logic [14:0] XML, XMS, XMSD, XMST, XTRAP;

  initial begin
    reset = 1'b1; stall = 1'b0; dmem_ready = 1'b1; Zero = 1'b0; BLT = 1'b0;
    opcode = R; funct3 = 3'b000;

    X0    = 15'd0;
    XF    = mk(0,1,0,0,0,0,0,0,2'b00,0,3'd0);
    XD    = mk(0,0,0,0,0,0,0,0,2'b00,0,3'd1);
    XER   = mk(0,0,0,0,0,0,0,0,2'b10,0,3'd2);
    XEI   = mk(0,0,0,0,0,0,1,0,2'b10,0,3'd2);
    XEM   = mk(0,0,0,0,0,0,1,0,2'b00,0,3'd2);
    XEBT  = mk(1,0,0,0,0,1,0,0,2'b01,0,3'd2);
    XEBN  = mk(1,0,0,0,0,0,0,0,2'b01,0,3'd2);
    XEBS  = mk(0,0,0,0,0,1,0,0,2'b01,0,3'd2);
    XWB   = mk(1,0,1,0,0,0,0,0,2'b00,0,3'd4);
    XWBL  = mk(1,0,1,0,0,0,0,1,2'b00,0,3'd4);
    XML   = mk(0,0,0,1,0,0,0,0,2'b00,0,3'd3);
    XMS   = mk(0,0,0,0,1,0,0,0,2'b00,0,3'd3);
    XMSD  = mk(1,0,0,0,1,0,0,0,2'b00,0,3'd3);
    XMST  = mk(0,0,0,0,0,0,0,0,2'b00,0,3'd3);
    XTRAP = mk(0,0,0,0,0,0,0,0,2'b00,1,3'd7);

    // rst stl rdy zero blt op f3 expected
    add(1,0,1,0,0,R,3'b000,X0);
    add(0,0,1,0,0,R,3'b000,XF);   add(0,0,1,0,0,R,3'b000,XD);
    add(0,0,1,0,0,R,3'b000,XER);  add(0,0,1,0,0,R,3'b000,XWB);
    add(0,1,1,0,0,I,3'b000,X0);   // stalled FETCH: no ir_write, state held
    add(0,0,1,0,0,I,3'b000,XF);   add(0,0,1,0,0,I,3'b000,XD);
    add(0,0,1,0,0,I,3'b000,XEI);  add(0,0,1,0,0,I,3'b000,XWB);
    add(0,0,1,1,0,BR,3'b000,XF);  add(0,0,1,1,0,BR,3'b000,XD);  add(0,0,1,1,0,BR,3'b000,XEBT);
    add(0,0,1,0,0,BR,3'b000,XF);  add(0,0,1,0,0,BR,3'b000,XD);  add(0,0,1,0,0,BR,3'b000,XEBN);
    add(0,0,1,0,0,BR,3'b101,XF);  add(0,0,1,0,0,BR,3'b101,XD);
    add(0,1,1,0,0,BR,3'b101,XEBS); add(0,0,1,0,0,BR,3'b101,XEBT);
    add(0,0,1,0,1,BR,3'b100,XF);  add(0,0,1,0,1,BR,3'b100,XD);  add(0,0,1,0,1,BR,3'b100,XEBT);
    add(0,0,1,0,0,BR,3'b001,XF);  add(0,0,1,0,0,BR,3'b001,XD);  add(0,0,1,0,0,BR,3'b001,XEBT);
    add(0,0,1,1,0,BR,3'b010,XF);  add(0,0,1,1,0,BR,3'b010,XD);  add(0,0,1,1,0,BR,3'b010,XEBN);
    // Load with two wait states: 7 cycles FETCH to FETCH
    add(0,0,1,0,0,LD,3'b011,XF);  add(0,0,1,0,0,LD,3'b011,XD);  add(0,0,1,0,0,LD,3'b011,XEM);
    add(0,0,0,0,0,LD,3'b011,XML); add(0,0,0,0,0,LD,3'b011,XML); add(0,0,1,0,0,LD,3'b011,XML);
    add(0,0,1,0,0,LD,3'b011,XWBL);
    // Store: one wait state, then stall overriding dmem_ready, then completion
    add(0,0,1,0,0,ST,3'b011,XF);  add(0,0,1,0,0,ST,3'b011,XD);  add(0,0,1,0,0,ST,3'b011,XEM);
    add(0,0,0,0,0,ST,3'b011,XMS); add(0,1,1,0,0,ST,3'b011,XMST); add(0,1,1,0,0,ST,3'b011,XMST);
    add(0,0,1,0,0,ST,3'b011,XMSD);
    add(0,0,1,0,0,R,3'b000,XF);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Illegal opcode: DECODE -> TRAP, absorbing for 20 cycles, only reset exits
    cyc(0,0,1,BAD,XD,"trap_decode");
    for (int i = 0; i < 20; i++) begin
      cyc(0,0,1,BAD,XTRAP,$sformatf("trap_hold%0d", i));
    end
    cyc(1,0,1,BAD,X0,"trap_reset");
    cyc(0,0,1,BAD,XF,"trap_exit_fetch");

    // Reset during MEM of a load aborts it with no RegWrite
    cyc(1,0,1,LD,X0,"abort_reset0");
    cyc(0,0,1,LD,XF,"abort_fetch");
    cyc(0,0,1,LD,XD,"abort_decode");
    cyc(0,0,1,LD,XEM,"abort_exec");
    cyc(0,0,0,LD,XML,"abort_mem");
    cyc(1,0,1,LD,X0,"abort_reset1");
    cyc(0,0,1,LD,XF,"abort_after");

    // Three back-to-back R-type instructions from reset
    cyc(1,0,1,R,X0,"perf_reset");
    for (int k = 0; k < 3; k++) begin
      cyc(0,0,1,R,XF,$sformatf("perf%0d_f", k));
      cyc(0,0,1,R,XD,$sformatf("perf%0d_d", k));
      cyc(0,0,1,R,XER,$sformatf("perf%0d_e", k));
      cyc(0,0,1,R,XWB,$sformatf("perf%0d_wb", k));
    end
    @(negedge clk);
    #1;
    $display("perf cycle_count=%0d instret=%0d", cycle_count, instret);
`ifdef MC_PERF_COUNTERS_EN
    check("cycle_count", cycle_count, 64'd12);
    check("instret", instret, 64'd3);
`else
    check("cycle_count_tied", cycle_count, 64'd0);
    check("instret_tied", instret, 64'd0);
`endif
    reset = 1'b1;
    #1;
    check("cycle_count_in_reset", cycle_count, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
